if_fetch_buffer: RTL

//  Fetch stage between the PC generator and decode. Takes the current fetch

---
 rtl/if_fetch_buffer_if.sv | 24 ++
 rtl/if_fetch_buffer.sv | 75 +++++++
 2 files changed

// File: rtl/if_fetch_buffer_if.sv
// if_fetch_buffer_if: PC, instruction-memory and decode-side signals of the fetch buffer
interface if_fetch_buffer_if;
  logic [31:0] pc_addr;
  logic        pc_nop;
  logic        flush;
  logic        stall;
  logic        pc_adv;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdat;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] instraddr;
  logic        fetch_err;
  modport master (
    input  pc_addr, pc_nop, flush, stall, mem_ack, mem_rdat,
    output pc_adv, mem_req, mem_addr, valid, instr, instraddr, fetch_err
  );
  modport slave (
    output pc_addr, pc_nop, flush, stall, mem_ack, mem_rdat,
    input  pc_adv, mem_req, mem_addr, valid, instr, instraddr, fetch_err
  );
endinterface

// File: rtl/if_fetch_buffer.sv
// if_fetch_buffer: single-outstanding instruction fetch into a DEPTH-entry FIFO for decode.
// Optional fetch timeout enabled by defining IFB_TIMEOUT_EN.
module if_fetch_buffer #(
  parameter int DEPTH       = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input logic               clock,
  input logic               rst,
  if_fetch_buffer_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
  state_t           state, state_nx;
  logic [AW:0]      count;
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [31:0]      instr_q [DEPTH];
  logic [31:0]      addr_q  [DEPTH];
  logic [31:0]      mem_addr;
  logic             issue, push, pop, valid, tmo, fetch_err;
`ifdef IFB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1) > 5 ? $clog2(TIMEOUT_CYC + 1) : 5;
  logic [CW-1:0] tcnt;
  // counter idles at zero so it starts from zero on WAIT entry and keeps running through DROP
  always_ff @(posedge clock or posedge rst)
    if (rst) begin
      tcnt      <= '0;
      fetch_err <= 1'b0;
    end else begin
      tcnt      <= state == IDLE ? '0 : tcnt + 1'b1;
      fetch_err <= state == WAIT && tmo && !bus.mem_ack;
    end
  assign tmo = state != IDLE && tcnt == CW'(TIMEOUT_CYC - 1);
`else
  assign tmo       = TIMEOUT_CYC < 0;
  assign fetch_err = 1'b0;
`endif
  always_ff @(posedge clock or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  assign issue = !bus.flush && !bus.pc_nop && count < (AW+1)'(DEPTH);
  always_comb
    state_nx = state == IDLE ? (issue ? WAIT : IDLE)
             : bus.mem_ack || tmo ? IDLE
             : state == WAIT && bus.flush ? DROP
             : state;
  always_comb begin
    bus.mem_req   = state != IDLE;
    bus.pc_adv    = state == WAIT && bus.mem_ack && !bus.flush;
    bus.mem_addr  = mem_addr;
    bus.fetch_err = fetch_err;
    valid         = count != '0;
    bus.valid     = valid;
    bus.instr     = valid ? instr_q[rd_ptr] : 32'h0000_0013;
    bus.instraddr = valid ? addr_q[rd_ptr] : 32'h0;
  end
  assign push = bus.pc_adv;
  assign pop  = valid && !bus.stall && !bus.flush;
  always_ff @(posedge clock or posedge rst)
    if (rst) begin
      mem_addr <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      mem_addr <= state == IDLE && issue ? bus.pc_addr : mem_addr;
      count    <= bus.flush ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
      rd_ptr   <= bus.flush ? '0 : rd_ptr + AW'(pop);
      wr_ptr   <= bus.flush ? '0 : wr_ptr + AW'(push);
    end
  always_ff @(posedge clock)
    if (push) begin
      instr_q[wr_ptr] <= bus.mem_rdat;
      addr_q[wr_ptr]  <= mem_addr;
    end
endmodule
